// File: rtl/line_window_3x3.sv
// Buffers the two previous active lines and presents a 3x3 pixel window with a fixed 2-clock latency.
// Build option LINE_WINDOW_ZERO_PAD_EN: zero the out-of-frame taps and flag every in-range active pixel as valid.
module line_window_3x3 #(
   parameter int DATA_W = 8,
   parameter int MAX_W  = 2048,
   parameter int ADDR_W = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   y_i,
   input  logic                dv_i,
   input  logic                hs_i,
   input  logic                vs_i,
   output logic [9*DATA_W-1:0] win_o,
   output logic                win_valid_o,
   output logic                dv_o,
   output logic                hs_o,
   output logic                vs_o,
   output logic                ovf_o
);

   localparam int            CW    = ADDR_W + 1;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_W);
   localparam logic [CW-1:0] TWO_C = CW'(2);

   // input-side position counters
   logic [CW-1:0]     col;
   logic [1:0]        row;

   // stage 1
   logic              dv_s1;
   logic              hs_s1;
   logic              vs_s1;
   logic [DATA_W-1:0] y_s1;
   logic [CW-1:0]     col_s1;
   logic [1:0]        row_s1;
   logic              oor_s1;

   // line buffers
   logic [DATA_W-1:0] lb_mid [MAX_W];
   logic [DATA_W-1:0] lb_top [MAX_W];
   logic [DATA_W-1:0] mid_rd;
   logic [DATA_W-1:0] top_rd;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;

   // stage 2
   logic [DATA_W-1:0] tap [9];
   logic              valid_d;

   logic              dv_fall;
   logic              vs_rise;
   logic              in_range;
   logic              oor;

   assign dv_fall  = dv_s1 & ~dv_i;
   assign vs_rise  = vs_i & ~vs_s1;
   assign in_range = dv_i & (col < MAX_C);
   assign oor      = dv_i & ~(col < MAX_C);
   assign addr     = col[ADDR_W-1:0];

   // col saturates so an absurdly long line cannot wrap back into range
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else begin
         if (dv_i) begin
            if (col != '1) col <= col + 1'b1;
         end else begin
            col <= '0;
         end
         if (vs_rise)
            row <= '0;
         else if (dv_fall && row != 2'd3)
            row <= row + 1'b1;
      end
   end

   // Read-first on lb_mid; the old line then moves into lb_top one clock later.
   always_ff @(posedge clk) begin
      if (in_range) begin
         mid_rd       <= lb_mid[addr];
         top_rd       <= lb_top[addr];
         lb_mid[addr] <= y_i;
      end
      if (wr_q)
         lb_top[addr_q] <= mid_rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= 1'b0;
         addr_q <= '0;
         dv_s1  <= 1'b0;
         hs_s1  <= 1'b0;
         vs_s1  <= 1'b0;
         y_s1   <= '0;
         col_s1 <= '0;
         row_s1 <= '0;
         oor_s1 <= 1'b0;
      end else begin
         wr_q   <= in_range;
         addr_q <= addr;
         dv_s1  <= dv_i;
         hs_s1  <= hs_i;
         vs_s1  <= vs_i;
         y_s1   <= y_i;
         col_s1 <= col;
         row_s1 <= row;
         oor_s1 <= oor;
      end
   end

`ifdef LINE_WINDOW_ZERO_PAD_EN
   assign valid_d = dv_s1 & ~oor_s1;
`else
   assign valid_d = dv_s1 & ~oor_s1 & (col_s1 >= TWO_C) & (row_s1 >= 2'd2);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_o        <= 1'b0;
         hs_o        <= 1'b0;
         vs_o        <= 1'b0;
         win_valid_o <= 1'b0;
         ovf_o       <= 1'b0;
      end else begin
         dv_o        <= dv_s1;
         hs_o        <= hs_s1;
         vs_o        <= vs_s1;
         win_valid_o <= valid_d;
         // a new overflow pixel outranks a coincident frame start
         if (oor_s1)
            ovf_o <= 1'b1;
         else if (vs_s1 & ~vs_o)
            ovf_o <= 1'b0;
      end
   end

   // Each row is a 3-deep column shift register, advanced only by active pixels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) tap[i] <= '0;
      end else if (dv_s1) begin
         for (int r = 0; r < 3; r++) begin
            tap[3*r]   <= tap[3*r+1];
            tap[3*r+1] <= tap[3*r+2];
         end
         tap[2] <= top_rd;
         tap[5] <= mid_rd;
         tap[8] <= y_s1;
      end
   end

`ifdef LINE_WINDOW_ZERO_PAD_EN
   logic [CW-1:0] col_s2;
   logic [1:0]    row_s2;
   logic [1:0]    col_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_s2 <= '0;
         row_s2 <= '0;
      end else begin
         col_s2 <= col_s1;
         row_s2 <= row_s1;
      end
   end

   assign col_lo = (col_s2 >= TWO_C) ? 2'd2 : col_s2[1:0];

   // tap (r,c) lies outside the frame when r < 2-row or c < 2-col
   always_comb begin
      win_o = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if ((r + int'(row_s2) >= 2) && (c + int'(col_lo) >= 2))
               win_o[DATA_W*(3*r+c) +: DATA_W] = tap[3*r+c];
         end
      end
   end
`else
   always_comb begin
      win_o = '0;
      for (int i = 0; i < 9; i++)
         win_o[DATA_W*i +: DATA_W] = tap[i];
   end
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3: default-size instance plus a MAX_W=8 instance for overflow.
// Expected windows come from a small pixel-value model queued per input pixel.
module tb_line_window_3x3;

`ifdef LINE_WINDOW_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [7:0]  y_i;
   logic        dv_i, hs_i, vs_i;
   logic [71:0] win_o, s_win_o;
   logic        win_valid_o, dv_o, hs_o, vs_o, ovf_o;
   logic        s_win_valid_o, s_dv_o, s_hs_o, s_vs_o, s_ovf_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_valid = 0;
   int          line_id = 0;
   int          base;
   bit          mon_en  = 1'b0;
   bit          have_first;
   logic [71:0] first_win;
   logic [71:0] exp_q[$];
   logic [11:0] dv_vec, hs_vec, vs_vec;

   line_window_3x3 dut (
      .clk(clk), .rst_n(rst_n), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
      .win_o(win_o), .win_valid_o(win_valid_o), .dv_o(dv_o), .hs_o(hs_o),
      .vs_o(vs_o), .ovf_o(ovf_o)
   );

   line_window_3x3 #(.DATA_W(8), .MAX_W(8), .ADDR_W(3)) dut_small (
      .clk(clk), .rst_n(rst_n), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
      .win_o(s_win_o), .win_valid_o(s_win_valid_o), .dv_o(s_dv_o), .hs_o(s_hs_o),
      .vs_o(s_vs_o), .ovf_o(s_ovf_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic [7:0] y, input logic dv, input logic hs, input logic vs);
      y_i  = y;
      dv_i = dv;
      hs_i = hs;
      vs_i = vs;
      @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      repeat (3) drive(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [71:0] exp_win(input int lid, input int row, input int c);
      logic [71:0] w;
      logic [7:0]  v;
      int          lr, cc;
      w = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            lr = lid - 2 + i;
            cc = c - 2 + j;
            v  = 8'((16 * lr + cc) & 255);
            if (PAD && ((row - 2 + i < 0) || (cc < 0))) v = 8'h00;
            w[8*(3*i+j) +: 8] = v;
         end
      end
      return w;
   endfunction

   // one active line: pixel value 16*line_id + col, then blanking
   task automatic drive_line(input int row, input int n, input bit vs_at_fall);
      for (int c = 0; c < n; c++) begin
         if (PAD || (row >= 2 && c >= 2)) exp_q.push_back(exp_win(line_id, row, c));
         drive(8'((16 * line_id + c) & 255), 1'b1, 1'b0, 1'b0);
      end
      drive(8'h00, 1'b0, 1'b0, vs_at_fall);
      repeat (3) drive(8'h00, 1'b0, 1'b0, 1'b0);
      line_id++;
   endtask

   // scoreboard
   always @(negedge clk) begin
      if (mon_en && win_valid_o) begin
         n_valid++;
         check_eq("win_valid_implies_dv", dv_o, 1'b1);
         if (exp_q.size() == 0) begin
            check_eq("win_unexpected_valid", win_valid_o, 1'b0);
         end else begin
            check_eq("win_taps", win_o, exp_q.pop_front());
         end
         if (!have_first) begin
            first_win  = win_o;
            have_first = 1'b1;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      y_i = 8'h00; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_eq("rst_win", win_o, 72'h0);
      check_eq("rst_valid", win_valid_o, 1'b0);
      check_eq("rst_dv", dv_o, 1'b0);
      check_eq("rst_hs", hs_o, 1'b0);
      check_eq("rst_vs", vs_o, 1'b0);
      check_eq("rst_ovf", ovf_o, 1'b0);
      check_eq("rst_small_ovf", s_ovf_o, 1'b0);
      rst_n = 1'b1;
      repeat (2) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // 5x4 frame, y = 16*row + col
      line_id = 0; n_valid = 0; have_first = 1'b0; mon_en = 1'b1;
      vs_pulse();
      for (int r = 0; r < 5; r++) drive_line(r, 4, 1'b0);
      check_eq("frame_valid_count", 72'(n_valid), PAD ? 72'd20 : 72'd6);
      check_eq("frame_q_drain", 72'(exp_q.size()), 72'd0);
`ifndef LINE_WINDOW_ZERO_PAD_EN
      check_eq("frame_win_2_2", first_win, 72'h222120121110020100);
`endif

      // strobe delay: single-cycle hs/vs pulses with 3-clock gaps
      mon_en = 1'b0;
      dv_vec = 12'b0011_0100_1110;
      hs_vec = 12'b0001_0001_0001;
      vs_vec = 12'b0100_0100_0100;
      for (int k = 0; k < 13; k++) begin
         if (k < 12) drive(8'(k), dv_vec[k], hs_vec[k], vs_vec[k]);
         else        drive(8'h00, 1'b0, 1'b0, 1'b0);
         if (k >= 1) begin
            check_eq("dly_dv", dv_o, dv_vec[k-1]);
            check_eq("dly_hs", hs_o, hs_vec[k-1]);
            check_eq("dly_vs", vs_o, vs_vec[k-1]);
            check_eq("dly_small_hs", s_hs_o, hs_vec[k-1]);
            check_eq("dly_small_vs", s_vs_o, vs_vec[k-1]);
            check_eq("dly_small_dv", s_dv_o, dv_vec[k-1]);
         end
      end
      repeat (3) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // vs rise coincident with dv fall restarts the row count
      mon_en = 1'b1; n_valid = 0;
      vs_pulse();
      drive_line(0, 4, 1'b0);
      drive_line(1, 4, 1'b0);
      drive_line(2, 4, 1'b0);
      drive_line(3, 4, 1'b1);
      drive_line(0, 4, 1'b0);
      drive_line(1, 4, 1'b0);
      drive_line(2, 4, 1'b0);
      check_eq("vsfall_valid_count", 72'(n_valid), PAD ? 72'd28 : 72'd6);
      check_eq("vsfall_q_drain", 72'(exp_q.size()), 72'd0);

      // a 2-pixel line never forms a full window
      base = n_valid;
      drive_line(3, 2, 1'b0);
      check_eq("short_line_valid_count", 72'(n_valid - base), PAD ? 72'd2 : 72'd0);
      check_eq("short_q_drain", 72'(exp_q.size()), 72'd0);

      // overflow on the MAX_W=8 instance with a 10-pixel line
      mon_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         drive(8'(k), 1'b1, 1'b0, 1'b0);
         if (k == 8) begin
            check_eq("ovf_px7_flag", s_ovf_o, 1'b0);
            check_eq("ovf_px7_valid", s_win_valid_o, 1'b1);
         end
         if (k == 9) begin
            check_eq("ovf_px8_flag", s_ovf_o, 1'b1);
            check_eq("ovf_px8_valid", s_win_valid_o, 1'b0);
         end
      end
      repeat (5) drive(8'h00, 1'b0, 1'b0, 1'b0);
      check_eq("ovf_sticky_blanking", s_ovf_o, 1'b1);
      check_eq("ovf_large_clear", ovf_o, 1'b0);
      vs_pulse();
      check_eq("ovf_cleared_by_vs", s_ovf_o, 1'b0);

`ifdef LINE_WINDOW_ZERO_PAD_EN
      // zero padding on the first pixel of a frame
      vs_pulse();
      drive(8'h37, 1'b1, 1'b0, 1'b0);
      drive(8'h38, 1'b1, 1'b0, 1'b0);
      check_eq("pad_first_win", win_o, {8'h37, 64'h0});
      check_eq("pad_first_valid", win_valid_o, 1'b1);
      repeat (4) drive(8'h00, 1'b0, 1'b0, 1'b0);
`endif

      // asynchronous reset in the middle of an active line
      for (int k = 0; k < 10; k++) drive(8'hFF, 1'b1, 1'b0, 1'b0);
      check_eq("pre_rst_dv", dv_o, 1'b1);
      check_eq("pre_rst_small_ovf", s_ovf_o, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_dv", dv_o, 1'b0);
      check_eq("async_rst_win", win_o, 72'h0);
      check_eq("async_rst_valid", win_valid_o, 1'b0);
      check_eq("async_rst_hs", hs_o, 1'b0);
      check_eq("async_rst_vs", vs_o, 1'b0);
      check_eq("async_rst_small_ovf", s_ovf_o, 1'b0);
      check_eq("async_rst_small_win", s_win_o, 72'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_eq("in_rst_dv", dv_o, 1'b0);
      rst_n = 1'b1;
      drive(8'hFF, 1'b1, 1'b0, 1'b0);
      check_eq("post_rst_dv_1clk", dv_o, 1'b0);
      drive(8'hFF, 1'b1, 1'b0, 1'b0);
      check_eq("post_rst_dv_2clk", dv_o, 1'b1);
      check_eq("post_rst_valid", win_valid_o, PAD);
      repeat (4) drive(8'h00, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
